// File: rtl/dither_pkg.sv
// Shared types and constants for the dither fill engine: modes, FSM states,
// error-diffusion weights and the signed error word used by every channel.
package dither_pkg;

    localparam int ERR_W = 11;

    localparam logic MODE_FLAT = 1'b0;
    localparam logic MODE_FS   = 1'b1;

    localparam int W_RIGHT = 7;
    localparam int W_BL    = 3;
    localparam int W_BELOW = 5;
    localparam int W_BR    = 1;

    typedef logic signed [ERR_W-1:0] err_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAW
    } state_t;

    // Weighted share of a quantisation error, rounded then floored by the arithmetic shift.
    function automatic err_t diffuse(input int w, input err_t err);
        int p;
        p = (w * int'(err) + 8) >>> 4;
        return err_t'(p);
    endfunction

endpackage

// File: rtl/dither_channel.sv
// One colour channel of the fill engine: clamp, quantise, error diffusion
// accumulators and the per-column error row buffer.
module dither_channel
    import dither_pkg::*;
#(
    parameter int BITS  = 3,
    parameter int MAX_W = 640,
    parameter int COL_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             fetch,
    input  logic             commit,
    input  logic             mode,
    input  logic             first_row,
    input  logic [COL_W-1:0] col,
    input  logic [COL_W-1:0] last_col,
    input  logic [7:0]       color,
    output logic [BITS-1:0]  q
);

    localparam int S    = 8 - BITS;
    localparam int HALF = (1 << S) >> 1;
    localparam int QMAX = (1 << BITS) - 1;

    err_t row_buf [MAX_W];

    err_t             e_right;
    err_t             a_prev;
    err_t             a_cur;
    err_t             tail;
    err_t             err_q;
    logic [COL_W-1:0] tail_col;
    logic             tail_pend;

    err_t             e_above_raw;
    err_t             e_r;
    err_t             e_a;
    err_t             v;
    err_t             err_c;
    logic [7:0]       vc;
    logic [9:0]       rounded;
    logic [BITS-1:0]  q_c;

    err_t             c_right;
    err_t             c_bl;
    err_t             c_below;
    err_t             c_br;

    logic             wr_en;
    logic [COL_W-1:0] wr_idx;
    err_t             wr_data;

    // The last column of a row is held in tail until the next row starts; bypass it
    // when a one-column rectangle reads that same entry.
    always_comb begin
        e_above_raw = (tail_pend && tail_col == col) ? tail : row_buf[col];
        e_r = (mode == MODE_FS) ? e_right : '0;
        e_a = (mode == MODE_FS && !first_row) ? e_above_raw : '0;
        v   = $signed({3'b000, color}) + e_r + e_a;

        if (v < 11'sd0) begin
            vc = 8'd0;
        end else if (v > 11'sd255) begin
            vc = 8'd255;
        end else begin
            vc = v[7:0];
        end

        rounded = {2'b00, vc} + 10'(HALF);
        if ((rounded >> S) > 10'(QMAX)) begin
            q_c = BITS'(QMAX);
        end else begin
            q_c = BITS'(rounded >> S);
        end
        err_c = err_t'(int'(vc) - (int'(q_c) << S));
    end

    assign c_right = diffuse(W_RIGHT, err_q);
    assign c_bl    = diffuse(W_BL, err_q);
    assign c_below = diffuse(W_BELOW, err_q);
    assign c_br    = diffuse(W_BR, err_q);

    // Single write port: the deferred tail lands during FETCH, the finished left
    // neighbour's entry lands on each accepted pixel.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = tail_col;
        wr_data = tail;
        if (fetch && tail_pend) begin
            wr_en = 1'b1;
        end else if (commit && col != '0) begin
            wr_en   = 1'b1;
            wr_idx  = col - 1'b1;
            wr_data = a_prev + c_bl;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            row_buf[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q         <= '0;
            err_q     <= '0;
            e_right   <= '0;
            a_prev    <= '0;
            a_cur     <= '0;
            tail      <= '0;
            tail_col  <= '0;
            tail_pend <= 1'b0;
        end else begin
            if (start) begin
                e_right   <= '0;
                a_cur     <= '0;
                tail_pend <= 1'b0;
            end
            if (fetch) begin
                q     <= q_c;
                err_q <= err_c;
                if (tail_pend) begin
                    tail_pend <= 1'b0;
                end
            end
            if (commit) begin
                if (col == last_col) begin
                    e_right   <= '0;
                    a_cur     <= '0;
                    tail      <= a_cur + c_below;
                    tail_col  <= col;
                    tail_pend <= 1'b1;
                end else begin
                    e_right <= c_right;
                    a_prev  <= a_cur + c_below;
                    a_cur   <= c_br;
                end
            end
        end
    end

endmodule

// File: rtl/dither_fill_engine.sv
// Rectangle fill engine: validates a command, walks the rectangle pixel by pixel
// and writes one dithered, packed byte per pixel through the de_* handshake.
module dither_fill_engine
    import dither_pkg::*;
#(
    parameter int FB_WIDTH = 640,
    parameter int MAX_W    = 640,
    parameter int R_BITS   = 3,
    parameter int G_BITS   = 3,
    parameter int B_BITS   = 2,
    parameter int ADDR_W   = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ack,
    output logic              busy,
    input  logic [15:0]       r0,
    input  logic [15:0]       r1,
    input  logic [15:0]       r2,
    input  logic [15:0]       r3,
    input  logic [15:0]       r4,
    input  logic [15:0]       r5,
    output logic              de_req,
    input  logic              de_ack,
    output logic [ADDR_W-1:0] de_addr,
    output logic [3:0]        de_nbyte,
    output logic              de_rnw,
    output logic [31:0]       de_w_data
);

    localparam int COL_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    if (R_BITS + G_BITS + B_BITS != 8) begin : g_bad_bits
        $error("dither_fill_engine: R_BITS+G_BITS+B_BITS must equal 8");
    end

    state_t state;
    state_t state_next;

    logic [15:0]       x_start;
    logic [15:0]       x_end;
    logic [15:0]       y_end;
    logic [15:0]       x;
    logic [15:0]       y;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    logic              mode;
    logic              first_row;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  last_col;

    logic              accept;
    logic              valid_cmd;
    logic              start;
    logic              fetch;
    logic              commit;
    logic              last_x;
    logic              last_y;
    logic [16:0]       span;
    logic [ADDR_W+1:0] pixel_addr;
    logic [R_BITS-1:0] q_r;
    logic [G_BITS-1:0] q_g;
    logic [B_BITS-1:0] q_b;
    logic              unused_bits;

    assign unused_bits = ^r5[7:1];

    assign span      = {1'b0, r2} - {1'b0, r0} + 17'd1;
    assign valid_cmd = (r2 >= r0) && (r3 >= r1) && (int'(r2) < FB_WIDTH) && (int'(span) <= MAX_W);
    assign accept    = (state == IDLE) && req && !ack;
    assign start     = accept && valid_cmd;
    assign fetch     = (state == FETCH);
    assign commit    = (state == DRAW) && de_ack;
    assign last_x    = (x == x_end);
    assign last_y    = (y == y_end);

    assign pixel_addr = (ADDR_W+2)'(int'(y) * FB_WIDTH + int'(x));

    assign busy      = (state != IDLE);
    assign de_req    = (state == DRAW);
    assign de_rnw    = 1'b0;
    assign de_w_data = {4{q_r, q_g, q_b}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = DRAW;
            DRAW:    if (de_ack) state_next = (last_x && last_y) ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, pixel walk and the registered memory address/lane select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack       <= 1'b0;
            de_addr   <= '0;
            de_nbyte  <= 4'b1111;
            x_start   <= '0;
            x_end     <= '0;
            y_end     <= '0;
            x         <= '0;
            y         <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            mode      <= MODE_FLAT;
            first_row <= 1'b1;
            col       <= '0;
            last_col  <= '0;
        end else begin
            ack <= accept;
            if (accept) begin
                x_start   <= r0;
                x_end     <= r2;
                y_end     <= r3;
                x         <= r0;
                y         <= r1;
                red       <= r4[15:8];
                green     <= r4[7:0];
                blue      <= r5[15:8];
                mode      <= r5[0];
                first_row <= 1'b1;
                col       <= '0;
                last_col  <= COL_W'(r2 - r0);
            end
            if (fetch) begin
                de_addr  <= pixel_addr[ADDR_W+1:2];
                de_nbyte <= ~(4'b0001 << pixel_addr[1:0]);
            end
            if (commit) begin
                if (last_x) begin
                    x         <= x_start;
                    col       <= '0;
                    y         <= y + 16'd1;
                    first_row <= 1'b0;
                end else begin
                    x   <= x + 16'd1;
                    col <= col + 1'b1;
                end
            end
        end
    end

    dither_channel #(.BITS(R_BITS), .MAX_W(MAX_W), .COL_W(COL_W)) u_red (
        .clk(clk), .rst_n(rst_n), .start(start), .fetch(fetch), .commit(commit),
        .mode(mode), .first_row(first_row), .col(col), .last_col(last_col),
        .color(red), .q(q_r)
    );

    dither_channel #(.BITS(G_BITS), .MAX_W(MAX_W), .COL_W(COL_W)) u_green (
        .clk(clk), .rst_n(rst_n), .start(start), .fetch(fetch), .commit(commit),
        .mode(mode), .first_row(first_row), .col(col), .last_col(last_col),
        .color(green), .q(q_g)
    );

    dither_channel #(.BITS(B_BITS), .MAX_W(MAX_W), .COL_W(COL_W)) u_blue (
        .clk(clk), .rst_n(rst_n), .start(start), .fetch(fetch), .commit(commit),
        .mode(mode), .first_row(first_row), .col(col), .last_col(last_col),
        .color(blue), .q(q_b)
    );

endmodule

// File: tb/tb_dither_fill_engine.sv
// Self-checking bench for dither_fill_engine: directed and random rectangles
// compared against a plain Floyd-Steinberg reference model.
module tb_dither_fill_engine;

    localparam int FBW = 640;
    localparam int MAXW = 640;
    localparam int RB = 3;
    localparam int GB = 3;
    localparam int BB = 2;
    localparam int AW = 18;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          ack;
    logic          busy;
    logic [15:0]   r0, r1, r2, r3, r4, r5;
    logic          de_req;
    logic          de_ack;
    logic [AW-1:0] de_addr;
    logic [3:0]    de_nbyte;
    logic          de_rnw;
    logic [31:0]   de_w_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    nbyte;
        logic [31:0]   data;
    } pix_t;

    pix_t exp_q[$];
    int above[3][MAXW];
    int below[3][MAXW];

    dither_fill_engine #(
        .FB_WIDTH(FBW), .MAX_W(MAXW), .R_BITS(RB), .G_BITS(GB), .B_BITS(BB), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .busy(busy),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5),
        .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
        .de_rnw(de_rnw), .de_w_data(de_w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int fl(input int p);
        return (p + 8) >>> 4;
    endfunction

    // Whole-rectangle reference: textbook error diffusion over a row array.
    task automatic build_model(input int xs, input int ys, input int xe, input int ye,
                               input logic [15:0] c4, input logic [15:0] c5);
        int bits[3];
        int cin[3];
        int er[3];
        int fs;
        bits = '{RB, GB, BB};
        cin  = '{int'(c4[15:8]), int'(c4[7:0]), int'(c5[15:8])};
        fs   = int'(c5[0]);
        exp_q.delete();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < MAXW; i++) below[c][i] = 0;
        for (int y = ys; y <= ye; y++) begin
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i <= xe - xs; i++) begin
                    above[c][i] = below[c][i];
                    below[c][i] = 0;
                end
                er[c] = 0;
            end
            for (int x = xs; x <= xe; x++) begin
                int pix;
                int pa;
                pix_t item;
                pix = 0;
                for (int c = 0; c < 3; c++) begin
                    int s, ea, e, v, q, err;
                    s  = 8 - bits[c];
                    ea = (fs == 1 && y != ys) ? above[c][x - xs] : 0;
                    e  = (fs == 1) ? er[c] : 0;
                    v  = cin[c] + e + ea;
                    if (v < 0) v = 0;
                    if (v > 255) v = 255;
                    q = (v + ((1 << s) >> 1)) >> s;
                    if (q > (1 << bits[c]) - 1) q = (1 << bits[c]) - 1;
                    err = v - (q << s);
                    er[c] = (x < xe) ? fl(7 * err) : 0;
                    if (x > xs) below[c][x - xs - 1] += fl(3 * err);
                    below[c][x - xs] += fl(5 * err);
                    if (x < xe) below[c][x - xs + 1] += fl(err);
                    pix = (pix << bits[c]) | q;
                end
                pa = y * FBW + x;
                item.addr  = AW'(pa >> 2);
                item.nbyte = ~(4'b0001 << (pa % 4));
                item.data  = {4{8'(pix)}};
                exp_q.push_back(item);
            end
        end
    endtask

    task automatic apply_stimulus(input int xs, input int ys, input int xe, input int ye,
                                  input logic [15:0] c4, input logic [15:0] c5,
                                  input int hold_min, input int hold_max, input int stop_after);
        int got;
        int n;
        int hold;
        int valid;
        valid = (xe >= xs && ye >= ys && xe < FBW && xe - xs + 1 <= MAXW) ? 1 : 0;
        if (valid == 1) build_model(xs, ys, xe, ye, c4, c5);
        else exp_q.delete();

        @(negedge clk);
        r0 = 16'(xs); r1 = 16'(ys); r2 = 16'(xe); r3 = 16'(ye); r4 = c4; r5 = c5;
        req = 1'b1;
        got = 0;
        for (int t = 0; t < 10 && got == 0; t++) begin
            @(negedge clk);
            if (ack === 1'b1) got = 1;
        end
        req = 1'b0;
        check_output("ack_seen", 32'(got), 32'd1);
        if (got == 0) return;
        check_output("busy_on_accept", {31'd0, busy}, 32'(valid));
        @(negedge clk);
        check_output("ack_one_cycle", {31'd0, ack}, 32'd0);

        if (valid == 0) begin
            for (int t = 0; t < 5; t++) begin
                check_output("invalid_no_de_req", {31'd0, de_req}, 32'd0);
                check_output("invalid_busy", {31'd0, busy}, 32'd0);
                @(negedge clk);
            end
            return;
        end

        n = exp_q.size();
        if (stop_after >= 0 && stop_after < n) n = stop_after;
        for (int i = 0; i < n; i++) begin
            got = 0;
            for (int t = 0; t < 20 && got == 0; t++) begin
                if (de_req === 1'b1) got = 1;
                else @(negedge clk);
            end
            check_output($sformatf("de_req_wait[%0d]", i), 32'(got), 32'd1);
            if (got == 0) return;
            check_output($sformatf("addr[%0d]", i), 32'(de_addr), 32'(exp_q[i].addr));
            check_output($sformatf("nbyte[%0d]", i), 32'(de_nbyte), 32'(exp_q[i].nbyte));
            check_output($sformatf("data[%0d]", i), de_w_data, exp_q[i].data);
            check_output($sformatf("rnw[%0d]", i), {31'd0, de_rnw}, 32'd0);
            hold = $urandom_range(hold_max, hold_min);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check_output($sformatf("hold_req[%0d]", i), {31'd0, de_req}, 32'd1);
                check_output($sformatf("hold_addr[%0d]", i), 32'(de_addr), 32'(exp_q[i].addr));
                check_output($sformatf("hold_data[%0d]", i), de_w_data, exp_q[i].data);
            end
            de_ack = 1'b1;
            @(negedge clk);
            de_ack = 1'b0;
            check_output($sformatf("de_req_gap[%0d]", i), {31'd0, de_req}, 32'd0);
            if (i == exp_q.size() - 1)
                check_output("busy_done", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; de_ack = 1'b0;
        r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0; r5 = '0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_ack", {31'd0, ack}, 32'd0);
        check_output("rst_de_req", {31'd0, de_req}, 32'd0);
        check_output("rst_nbyte", 32'(de_nbyte), 32'hF);
        check_output("rst_addr", 32'(de_addr), 32'd0);
        check_output("rst_data", de_w_data, 32'd0);
        rst_n = 1'b1;

        $display("[TB] flat 4-pixel row");
        apply_stimulus(0, 0, 3, 0, 16'h8000, 16'hFF00, 0, 1, -1);
        $display("[TB] Floyd-Steinberg 4-pixel row");
        apply_stimulus(0, 0, 3, 0, 16'h1010, 16'h1001, 0, 1, -1);
        $display("[TB] single pixel at right edge");
        apply_stimulus(639, 1, 639, 1, 16'h5AC3, 16'h7700, 0, 0, -1);
        $display("[TB] invalid commands");
        apply_stimulus(10, 0, 5, 0, 16'h1234, 16'h5601, 0, 0, -1);
        apply_stimulus(600, 3, 640, 3, 16'h1234, 16'h5601, 0, 0, -1);
        apply_stimulus(0, 9, 3, 8, 16'h1234, 16'h5601, 0, 0, -1);
        $display("[TB] de_ack withheld");
        apply_stimulus(100, 2, 102, 2, 16'h9F3C, 16'h6101, 5, 5, -1);
        $display("[TB] one-column FS rectangle");
        apply_stimulus(5, 5, 5, 8, 16'h4477, 16'hA901, 0, 1, -1);
        $display("[TB] right-edge FS block");
        apply_stimulus(632, 0, 639, 3, 16'h3366, 16'h9901, 0, 1, -1);

        $display("[TB] random rectangles");
        for (int k = 0; k < 8; k++) begin
            int w, h, xs, ys;
            w  = $urandom_range(10, 1);
            h  = $urandom_range(4, 1);
            xs = $urandom_range(FBW - w, 0);
            ys = $urandom_range(400, 0);
            apply_stimulus(xs, ys, xs + w - 1, ys + h - 1, 16'($urandom),
                           {8'($urandom), 7'd0, 1'($urandom)}, 0, 2, -1);
        end

        $display("[TB] reset mid-rectangle");
        apply_stimulus(20, 10, 25, 12, 16'hE1B7, 16'hC801, 0, 1, 7);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midrst_de_req", {31'd0, de_req}, 32'd0);
        check_output("midrst_busy", {31'd0, busy}, 32'd0);
        check_output("midrst_ack", {31'd0, ack}, 32'd0);
        check_output("midrst_nbyte", 32'(de_nbyte), 32'hF);
        rst_n = 1'b1;
        apply_stimulus(20, 10, 25, 12, 16'h2F80, 16'h4501, 0, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dither_fill_engine.md
Name: dither_fill_engine

Overview:
- Parametrised next-generation rectangle fill engine with error-diffusion dithering.
- Accepts a command (rectangle plus 24-bit RGB colour plus mode) over the register req/ack interface.
- Writes one packed quantised pixel per byte to the framebuffer through the de_* memory handshake.
- Generalises the fixed RGB332 / 640-wide engine: configurable frame width, row-buffer depth and per-channel output widths.
- Adds a selectable mode: flat quantise or full 4-neighbour Floyd-Steinberg.
- Adds command validation.

Parameters:
- FB_WIDTH, 640: framebuffer pixels per row; pixel address = y*FB_WIDTH + x.
- MAX_W, 640: maximum rectangle width; depth of the error row buffer.
- R_BITS, 3: red output bits.
- G_BITS, 3: green output bits.
- B_BITS, 2: blue output bits. R_BITS+G_BITS+B_BITS must equal 8 (elaboration error otherwise).
- ADDR_W, 18: de_addr width (word address).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req  in  1  command request
- ack  out  1  one-cycle command accept pulse
- busy  out  1  high while a command is executing
- r0  in  16  x_start
- r1  in  16  y_start
- r2  in  16  x_end (inclusive)
- r3  in  16  y_end (inclusive)
- r4  in  16  {red[7:0], green[7:0]}
- r5  in  16  {blue[7:0], 7'b0, mode}; mode 0 = flat, 1 = Floyd-Steinberg
- de_req  out  1  memory write request
- de_ack  in  1  memory accept
- de_addr  out  ADDR_W  word address = pixel_addr >> 2
- de_nbyte  out  4  active-low byte-lane enables; lane pixel_addr[1:0] low, others high
- de_rnw  out  1  constant 0
- de_w_data  out  32  packed pixel {r_q, g_q, b_q} replicated in all four bytes

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n low at a clk edge): state IDLE; ack=0, de_req=0, busy=0, de_nbyte=4'b1111, de_addr=0, de_w_data=0. Applies mid-command: the command is abandoned and the partial rectangle is left as drawn. Row-buffer contents are not cleared.
- States: IDLE, FETCH, DRAW.
- IDLE, req=1:
  - Latch r0..r5; assert ack for exactly one cycle.
  - Invalid command (x_end<x_start, y_end<y_start, x_end>=FB_WIDTH, or x_end-x_start+1>MAX_W): stay IDLE, no de_req.
  - Otherwise go to FETCH with x=x_start, y=y_start, first_row=1.
- req while busy: ignored. No ack until back in IDLE.
- busy=1 in FETCH and DRAW.
- FETCH (1 cycle):
  - Read row-buffer entry [x-x_start]; compute the pixel.
  - Register de_addr, de_nbyte, de_w_data; go to DRAW.
- DRAW:
  - de_req=1; address and data stable until de_ack.
  - On de_ack: commit the error updates and advance x (x_end wraps to x_start, y+1, first_row=0).
  - Then FETCH next cycle, with de_req=0 for that cycle.
  - After the last pixel (x_end,y_end) acks: IDLE.
- Pixel arithmetic, per channel, input C, S = 8-BITS:
  - v = C + e_right + e_above. e_above is forced to 0 when first_row. v is signed 11-bit.
  - Clamp v to 0..255.
  - q = (v + 2^(S-1)) >> S, saturated to 2^BITS-1.
  - err = v - (q << S), signed.
  - Mode 0 forces e_right = e_above = 0 (pure rounding quantise).
- Diffusion (mode 1):
  - Each contribution is (w*err + 8) >>> 4 (arithmetic shift, floor).
  - Weights: right w=7, below-left w=3, below w=5, below-right w=1.
  - Contributions falling outside [x_start, x_end] are discarded.
  - Below contributions accumulate into next-row entries via three running registers; the completed entry is written to the row buffer once its column is final.
  - e_right is reset to 0 at each row start.
- Row buffer: depth MAX_W per channel, 11-bit signed. One read and one write per pixel maximum; no read/write collision on the same entry in the same cycle.

Decomposition:
- Package dither_pkg:
  - mode encodings MODE_FLAT / MODE_FS;
  - state enum;
  - diffusion weights 7/3/5/1;
  - error width constant ERR_W=11.
- Sub-module dither_channel (parameter BITS): clamp, quantise, err, diffusion accumulators and row buffer for one channel; instantiated three times.

Test Plan:
- Flat mode, rect (0,0)-(3,0), r4=16'h8000, r5=16'hFF00 -> four writes, de_addr=0, de_nbyte 1110/1101/1011/0111 in order, de_w_data=32'h83838383 each, then busy falls.
- FS mode, rect (0,0)-(3,0), r4=16'h1010, r5=16'h1001 -> r and g sequence 1,0,1,0, b all 0; de_w_data bytes 0x24, 0x00, 0x24, 0x00.
- Single pixel at (639,1), flat -> pixel_addr 1279, de_addr=319, de_nbyte=4'b0111, exactly one write.
- Invalid command x_start=10, x_end=5 -> one ack pulse, busy stays 0, no de_req.
- de_ack withheld 5 cycles in DRAW -> de_req, de_addr, de_w_data held constant; the pixel advances only on de_ack.
- rst_n low for one cycle mid-rectangle -> next cycle de_req=0, busy=0, ack=0. A new req is accepted and its first row ignores stale row-buffer errors, matching a fresh-reset run.
